// File: rtl/im_program_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into 32-bit
// words and writes them to IM while holding the CPU off until the load completes.
module im_program_loader #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [4:0]  word_count_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_in_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               byte_ready_q, byte_ready_d;
    logic               mem_write_q, mem_write_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               count_ok_c;
    logic               last_word_c;

    assign count_ok_c  = (word_count_i != '0) && (32'(word_count_i) <= DEPTH);
    assign last_word_c = (32'(idx_q) + 32'd1) == 32'(count_q);

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= BASE_ADDR;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            byte_cnt_q   <= byte_cnt_d;
            mem_data_q   <= mem_data_d;
            mem_addr_q   <= mem_addr_d;
            byte_ready_q <= byte_ready_d;
            mem_write_q  <= mem_write_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with it
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        mem_data_d = mem_data_q;
        mem_addr_d = mem_addr_q;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (count_ok_c) begin
                        state_d    = S_COLLECT;
                        count_d    = word_count_i;
                        idx_d      = '0;
                        byte_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (byte_valid_i && byte_ready_q) begin
                    mem_data_d[{byte_cnt_q, 3'b000} +: 8] = byte_in_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = S_WRITE;
                        mem_addr_d = BASE_ADDR + (32'(idx_q) << 2);
                    end
                end
            end
            S_WRITE: begin
                if (last_word_c) begin
                    state_d    = S_DONE;
                    mem_addr_d = BASE_ADDR;
                end else begin
                    state_d = S_COLLECT;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_COLLECT);
        mem_write_d  = (state_d == S_WRITE);
        cpu_hold_d   = (state_d == S_COLLECT) || (state_d == S_WRITE);
        busy_d       = cpu_hold_d;
        done_d       = (state_d == S_DONE);
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_im_program_loader.sv
// Scoreboard bench for im_program_loader: the driver queues expected IM writes, a
// negedge monitor pops and checks them and mirrors every write into a local IM.
module tb_im_program_loader;

    localparam logic [31:0] BASE = 32'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [4:0]  word_count_i;
    logic        byte_valid_i;
    logic [7:0]  byte_in_i;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int writes_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int last_wr_cyc = 0;

    wr_t         exp_q[$];
    logic [31:0] im[16];
    logic [31:0] prog[16];

    im_program_loader #(.DEPTH(16), .BASE_ADDR(BASE)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .byte_valid_i (byte_valid_i),
        .byte_in_i    (byte_in_i),
        .byte_ready_o (byte_ready_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on each IM write and checks the done pulse
    always @(negedge clk) begin
        wr_t e;
        int  d;
        if (!reset_i) begin
            if (mem_write_o) begin
                writes_seen++;
                last_wr_cyc = cyc;
                check("ready_low_in_write", 32'(byte_ready_o), 32'd0);
                check("hold_during_write", 32'(cpu_hold_o), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write",
                             mem_addr_o, mem_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr_o, e.addr);
                    check("write_data", mem_data_o, e.data);
                end
                im[mem_addr_o[5:2]] = mem_data_o;
            end
            if (done_o) begin
                done_seen++;
                d = cyc - last_wr_cyc;
                check("done_after_write", 32'((d >= 1) && (d <= 2)), 32'd1);
                check("hold_dropped_at_done", 32'(cpu_hold_o), 32'd0);
                check("busy_dropped_at_done", 32'(busy_o), 32'd0);
                check("addr_base_at_done", mem_addr_o, BASE);
            end
            if (err_o) err_seen++;
        end
    end

    // Present one byte after 'gap' idle cycles; returns right after it is accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic accepted;
        accepted = 1'b0;
        if (gap > 0) begin
            byte_valid_i = 1'b0;
            byte_in_i    = 8'hXX;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b1;
        byte_in_i    = b;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: byte %h not accepted, required acceptance", b);
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid held high, mode 1: one gap per word plus start spam, mode 2: random gaps
    task automatic load(input int n, input int mode);
        int e0;
        int d0;
        int gap;
        e0 = err_seen;
        d0 = done_seen;
        start_i      = 1'b1;
        word_count_i = 5'(n);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("hold_after_start", 32'(cpu_hold_o), 32'd1);
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("ready_in_collect", 32'(byte_ready_o), 32'd1);
        if (mode == 1) begin
            start_i      = 1'b1;
            word_count_i = 5'd0;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(wr_t'{addr: BASE + 32'(4 * i), data: prog[i]});
            for (int b = 0; b < 4; b++) begin
                if (mode == 0)      gap = 0;
                else if (mode == 1) gap = (b == 2) ? 1 : 0;
                else                gap = $urandom_range(0, 3);
                send_byte(prog[i][8*b +: 8], gap);
            end
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done_seen != d0) break;
            @(negedge clk);
        end
        check("done_pulses", 32'(done_seen - d0), 32'd1);
        check("no_err_while_busy", 32'(err_seen - e0), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("idle_after_load", 32'({busy_o, cpu_hold_o, byte_ready_o}), 32'd0);
    endtask

    initial begin
        int w0;
        reset_i      = 1'b1;
        start_i      = 1'b0;
        word_count_i = 5'd0;
        byte_valid_i = 1'b0;
        byte_in_i    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 32'({byte_ready_o, mem_write_o, cpu_hold_o, busy_o, done_o, err_o}),
              32'd0);
        check("reset_addr", mem_addr_o, BASE);
        check("reset_data", mem_data_o, 32'h0);
        reset_i = 1'b0;

        // Rejected starts: count 0 and count above depth
        w0 = writes_seen;
        for (int k = 0; k < 2; k++) begin
            start_i      = 1'b1;
            word_count_i = (k == 0) ? 5'd0 : 5'd17;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            check("err_pulse", 32'(err_o), 32'd1);
            check("busy_on_err", 32'({busy_o, cpu_hold_o}), 32'd0);
            @(posedge clk);
            #1;
            check("err_one_cycle", 32'(err_o), 32'd0);
        end
        check("no_write_on_err", 32'(writes_seen - w0), 32'd0);

        // Single word, bytes 05 20 D4 68 back to back
        prog[0] = 32'h68D42005;
        load(1, 0);
        check("im_word0", im[0], 32'h68D42005);

        // Three words with gaps while start is held
        prog[0] = 32'h00000013;
        prog[1] = 32'hDEADBEEF;
        prog[2] = 32'h12345678;
        load(3, 1);

        // Valid held continuously across WRITE cycles
        prog[0] = 32'h03020100;
        prog[1] = 32'h07060504;
        prog[2] = 32'h0B0A0908;
        prog[3] = 32'h0F0E0D0C;
        load(4, 0);

        // Reset after two bytes of the first word
        w0 = writes_seen;
        start_i      = 1'b1;
        word_count_i = 5'd2;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        byte_valid_i = 1'b0;
        reset_i      = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("abort_flags", 32'({byte_ready_o, mem_write_o, cpu_hold_o, busy_o}), 32'd0);
        check("abort_data_cleared", mem_data_o, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check("no_write_after_abort", 32'(writes_seen - w0), 32'd0);
        prog[0] = 32'hCAFEF00D;
        load(1, 0);
        check("im_word0_after_abort", im[0], 32'hCAFEF00D);

        // Full depth with random gaps, then read every word back
        for (int i = 0; i < 16; i++) prog[i] = 32'h1000_0000 * 32'(i) + 32'h00A5_5A00 + 32'(i * 3);
        w0 = writes_seen;
        load(16, 2);
        check("full_write_count", 32'(writes_seen - w0), 32'd16);
        for (int i = 0; i < 16; i++) check("readback", im[i], prog[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
